fpu_req_sequencer: RTL

FPU_REQ_SEQUENCER -- requirements
Module: fpu_req_sequencer

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_req_sequencer_if.sv | 23 ++
 rtl/fpu_req_fifo.sv | 69 ++++++
 rtl/fpu_req_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request sequencer: op encodings, the
// timeout result value, FSM state codes and the queued request layout.
package fpu_pkg;

  localparam logic [4:0]  OP_ADD  = 5'b00001;
  localparam logic [4:0]  OP_SUB  = 5'b00010;
  localparam logic [4:0]  OP_MUL  = 5'b00100;
  localparam logic [4:0]  OP_DIV  = 5'b01000;
  localparam logic [4:0]  OP_SQRT = 5'b10000;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_ISSUE = 2'd1;
  localparam logic [1:0]  ST_WAIT  = 2'd2;

  // 69-bit queue entry: operand A, operand B, one-hot op
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
  } fpu_req_t;

  function automatic logic is_onehot(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  function automatic logic is_multihot(input logic [4:0] v);
    return (v & (v - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/fpu_req_sequencer_if.sv
// Issue/return handshake between the sequencer (master) and the FP core (slave).
interface fpu_req_sequencer_if;
  import fpu_pkg::*;

  logic        core_valid;
  logic        core_ready;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [4:0]  core_op;
  logic        core_res_valid;
  logic [31:0] core_res;

  modport master (
    output core_valid, core_a, core_b, core_op,
    input  core_ready, core_res_valid, core_res
  );

  modport slave (
    input  core_valid, core_a, core_b, core_op,
    output core_ready, core_res_valid, core_res
  );

endinterface

// File: rtl/fpu_req_fifo.sv
// Request queue: power-of-two depth, registered full/empty flags,
// head visible combinationally from storage.
module fpu_req_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  logic     i_pop,
  input  fpu_req_t i_data,
  output fpu_req_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fpu_req_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  // occupancy after this cycle's push/pop
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW + 1)'(1);
      2'b01:   w_count_nxt = r_count - (AW + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // storage write port
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/fpu_req_sequencer.sv
// Queues FPU requests and issues them one at a time to an FP core,
// returning results in push order with a QNAN substitute on core timeout.
module fpu_req_sequencer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                fpu1in,
  input  logic [31:0]                fpu2in,
  input  logic [4:0]                 fpuen,
  output logic [31:0]                fpuout,
  output logic                       fpu_done,
  output logic                       fpu_busy,
  output logic [2:0]                 err,
  fpu_req_sequencer_if.master        core
);

  localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_tmo_cnt;
  logic [31:0]   r_out;
  logic          r_done;
  logic [2:0]    r_err;
  logic          r_core_valid;
  logic [31:0]   r_core_a;
  logic [31:0]   r_core_b;
  logic [4:0]    r_core_op;

  fpu_req_t w_wdata;
  fpu_req_t w_head;
  logic     w_full;
  logic     w_empty;
  logic     w_legal;
  logic     w_multi;
  logic     w_push;
  logic     w_fire;
  logic     w_res;
  logic     w_tmo;
  logic     w_enter_issue;

  assign w_legal = is_onehot(fpuen);
  assign w_multi = is_multihot(fpuen);
  assign w_push  = w_legal && !w_full;
  assign w_wdata = '{a: fpu1in, b: fpu2in, op: fpuen};
  assign w_fire  = (r_state == ST_ISSUE) && r_core_valid && core.core_ready;
  assign w_res   = (r_state == ST_WAIT) && core.core_res_valid;
  assign w_tmo   = (r_state == ST_WAIT) && !core.core_res_valid && (r_tmo_cnt == TMO_LAST);

  fpu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_fire),
    .i_data  (w_wdata),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // next-state decode; a completing WAIT re-issues only if work is already queued
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_state_nxt = ST_ISSUE;
        else          w_state_nxt = ST_IDLE;
      end
      ST_ISSUE: begin
        if (w_fire) w_state_nxt = ST_WAIT;
        else        w_state_nxt = ST_ISSUE;
      end
      ST_WAIT: begin
        if (w_res || w_tmo) w_state_nxt = w_empty ? ST_IDLE : ST_ISSUE;
        else                w_state_nxt = ST_WAIT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_issue = (w_state_nxt == ST_ISSUE) && (r_state != ST_ISSUE);

  // state, result, error and core-issue registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_tmo_cnt    <= '0;
      r_out        <= 32'h0000_0000;
      r_done       <= 1'b0;
      r_err        <= 3'b000;
      r_core_valid <= 1'b0;
      r_core_a     <= 32'h0000_0000;
      r_core_b     <= 32'h0000_0000;
      r_core_op    <= 5'b00000;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_res || w_tmo;
      r_err   <= r_err | {w_tmo, w_legal && w_full, w_multi};

      if (w_res)      r_out <= core.core_res;
      else if (w_tmo) r_out <= QNAN;

      if ((r_state == ST_WAIT) && !(w_res || w_tmo)) r_tmo_cnt <= r_tmo_cnt + CW'(1);
      else                                           r_tmo_cnt <= '0;

      // operands are captured once on entry and held until the core accepts
      if (w_enter_issue) begin
        r_core_valid <= 1'b1;
        r_core_a     <= w_head.a;
        r_core_b     <= w_head.b;
        r_core_op    <= w_head.op;
      end else if (w_fire) begin
        r_core_valid <= 1'b0;
        r_core_a     <= 32'h0000_0000;
        r_core_b     <= 32'h0000_0000;
        r_core_op    <= 5'b00000;
      end
    end
  end

  assign fpuout          = r_out;
  assign fpu_done        = r_done;
  assign fpu_busy        = w_full;
  assign err             = r_err;
  assign core.core_valid = r_core_valid;
  assign core.core_a     = r_core_a;
  assign core.core_b     = r_core_b;
  assign core.core_op    = r_core_op;

endmodule
